// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_defs (package)
//  Description : Shared state encodings and parameter checks for the
//                bit-serial adder/subtractor controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_WIDTH_MIN = 2;
    localparam int c_WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_if
//  Description : Request/result bundle between a requester and the serial
//                adder controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : fa_bit
//  Description : One-bit combinational full adder; the shared datapath cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_bit (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      co
);
    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ cin;
    assign co  = (a & b) | (cin & w_p);
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add/subtract controller; sequences one full-adder
//                cell over WIDTH cycles, LSB first, with start/busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    serial_add_if.slave bus
);
    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    generate
        if (!width_legal(WIDTH)) begin : g_width_bad
            $error("serial_add_ctrl: WIDTH out of legal range 2..32");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_s_sr;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_fa_s;
    logic               w_fa_co;
    logic [WIDTH-1:0]   w_s_next;

    fa_bit u_fa (
        .a   (r_a_sr[0]),
        .b   (r_b_sr[0]),
        .cin (r_carry),
        .s   (w_fa_s),
        .co  (w_fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB result.
    assign w_s_next = WIDTH'({w_fa_s, r_s_sr} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub | bus.cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s_sr  <= w_s_next;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_carry <= w_fa_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        // r_carry here is the carry into the MSB position.
                        r_sum   <= w_s_next;
                        r_cout  <= w_fa_co;
                        r_ovf   <= r_carry ^ w_fa_co;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   cyc;

    serial_add_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present a request for one cycle, then scramble inputs to prove they were latched.
    task automatic issue(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic ci);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sub   = ~s;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.cin   = ~ci;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input string tag, input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        issue(s, av, bv, ci);
        wait_done(n);
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(bus.done), 0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
        chk({tag, "_sum_hold"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        int nb, nd, n, t_prev;
        logic [7:0] va [0:3];
        logic [7:0] vb [0:3];
        logic [7:0] ve [0:2];

        n_pass = 0; n_total = 0; cyc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst_n = 1'b1;

        op("add5a33", 1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        op("addff01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op("addff00c", 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        op("sub1001", 1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0);
        op("sub0001", 1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        op("sub8001", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Stray start during RUN must not be queued or disturb the result.
        issue(1'b0, 8'h12, 8'h34, 1'b0);
        nb = 0; nd = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) nd++;
            if (i == 2) begin
                bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_busy_cycles", nb, 9);
        chk("ign_done_pulses", nd, 1);
        chk("ign_sum", 32'(bus.sum), 32'h46);
        chk("ign_cout", 32'(bus.cout), 0);

        // Reset mid-operation abandons it without a done pulse.
        issue(1'b0, 8'h05, 8'h06, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_done", 32'(bus.done), 0);
        chk("mrst_sum", 32'(bus.sum), 0);
        chk("mrst_cout", 32'(bus.cout), 0);
        chk("mrst_ovf", 32'(bus.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        chk("mrst_no_done", nd, 0);
        op("add0101", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Back-to-back with start held high; next operands staged after each accept.
        va[0] = 8'h11; vb[0] = 8'h22; ve[0] = 8'h33;
        va[1] = 8'h7F; vb[1] = 8'h01; ve[1] = 8'h80;
        va[2] = 8'hC8; vb[2] = 8'h64; ve[2] = 8'h2C;
        va[3] = 8'h00; vb[3] = 8'h00;
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b0; bus.a = va[0]; bus.b = vb[0]; bus.start = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (bus.busy !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            bus.a = va[i+1]; bus.b = vb[i+1];
            wait_done(n);
            chk($sformatf("b2b%0d_done_seen", i), 32'(bus.done), 1);
            chk($sformatf("b2b%0d_sum", i), 32'(bus.sum), 32'(ve[i]));
            if (i > 0) chk($sformatf("b2b%0d_interval", i), cyc - t_prev, 10);
            t_prev = cyc;
            @(negedge clk);
            chk($sformatf("b2b%0d_hold", i), 32'(bus.sum), 32'(ve[i]));
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_last_ovf", 32'(bus.ovf), 0);
        chk("b2b_last_cout", 32'(bus.cout), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller.
- Reuses a single one-bit full-adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands, LSB first.
- Provides the start/busy/done handshake, operand and carry sequencing, and registered result capture.
- Used where area matters more than latency. Sits between a requester (control FSM or test harness) and the shared one-bit adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in for add mode; sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Any operation in progress is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge, load A_sr=a, B_sr=(sub ? ~b : b), carry=(sub ? 1 : cin), cnt=0, and go to RUN.
  - If start=0, stay in IDLE.
- RUN, each edge:
  - Full-adder inputs are (A_sr[0], B_sr[0], carry).
  - Shift the FA sum bit into S_sr at the MSB end (right shift); shift A_sr and B_sr right by one.
  - carry <= FA carry-out; cnt <= cnt+1.
  - When cnt==WIDTH-1: also capture c_msb_in = carry (the carry into the MSB), and go to DONE.
- Result register update, on the edge leaving RUN:
  - sum <= final S_sr (including the bit computed that cycle).
  - cout <= FA carry-out.
  - ovf <= c_msb_in XOR FA carry-out.
- DONE:
  - done=1 for exactly this one cycle; go to IDLE unconditionally on the next edge.
- Latency and hold:
  - start sampled at edge k → done high in the cycle following edge k+WIDTH.
  - busy is high for WIDTH+1 cycles.
  - sum/cout/ovf hold their values until the next completion or reset; they are not cleared when start is accepted.
- start in RUN or DONE is ignored (not queued).
- Operand/sub/cin changes after the sampling edge have no effect.
- Back-to-back operation: start high in the first IDLE cycle after DONE is accepted, giving a minimum issue interval of WIDTH+2 cycles.
- Width rules:
  - cnt is $clog2(WIDTH) bits wide.
  - All arithmetic is modulo 2^WIDTH.
  - Subtraction is two's complement (invert B, carry-in 1).
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared include/package `serial_add_defs`:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - The WIDTH legal-range check.
- One sub-module, fa_bit:
  - Combinational one-bit full adder (a, b, cin → s, co).
  - Instantiated once; it is the shared datapath resource.
- Everything else lives in serial_add_ctrl: FSM, counter, shift registers, carry flop and result registers.

Test Plan (WIDTH=8):
- add 0x5A+0x33, cin=0 → after 8 RUN cycles done=1; sum=0x8D, cout=0, ovf=1.
- add 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0. Repeat with cin=1 and b=0x00 → sum=0x00, cout=1.
- sub 0x10-0x01 → sum=0x0F, cout=1, ovf=0. Then sub 0x00-0x01 → sum=0xFF, cout=0, ovf=0. Then sub 0x80-0x01 → sum=0x7F, cout=1, ovf=1.
- Start pulsed again at RUN cycle 3 with different operands → ignored; exactly one done pulse; result equals the first operation; busy stays high for 9 cycles total.
- rst_n low at RUN cycle 4 → immediately busy=0, done=0, sum=0, cout=0, ovf=0. After release, a fresh 0x01+0x01 → sum=0x02.
- Back-to-back: start held high continuously → done pulses every 10 cycles; each result matches the operands sampled on its accepting edge; sum holds between pulses.
